refr_sched_1rw: RTL and testbench
=================================

Name: refr_sched_1rw

Overview:
- Refresh scheduler sitting directly upstream of the 1RW multi-port mux; drives its prefr input and gates the primary pread/pwrite strobes.
- Accrues one refresh credit per refresh interval.
- Spends credits opportunistically on cycles with no primary access; forces a refresh (stalling all primary ports for one cycle) when credits saturate.
- Enforces a minimum spacing between refreshes.

Parameters:
- NUMRDPT, 1, read-only primary ports
- NUMRWPT, 1, read/write primary ports
- NUMWRPT, 2, write-only primary ports
- REFP, 64, refresh interval in clk cycles (>=2)
- MAXPEND, 8, credit saturation / force threshold (>=1)
- BITPEND, 4, credit counter width; must satisfy 2^BITPEND > MAXPEND
- REFGAP, 3, minimum clk cycles from one prefr pulse to the next (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pread  in  NUMRDPT+NUMRWPT  requested reads
- pwrite  in  NUMRWPT+NUMWRPT  requested writes
- refr_dis  in  1  suspend issue; credits still accrue
- pread_o  out  NUMRDPT+NUMRWPT  gated reads to mux pread
- pwrite_o  out  NUMRWPT+NUMWRPT  gated writes to mux pwrite
- ready  out  1  0 = primary access blocked this cycle
- prefr  out  1  refresh strobe to mux prefr
- refr_pend  out  BITPEND  current credit count
- refr_ovfl  out  1  sticky: a credit was lost at saturation

Behaviour:
- Clock and reset: single clock; reset is synchronous, active-high.
- Reset values:
  - timer=REFP-1, pend=0, gap=0, refr_ovfl=0.
  - During the rst cycle prefr=0, ready=1, pread_o=pread, pwrite_o=pwrite.
- Timer:
  - Decrements every cycle.
  - At 0 it asserts tick and reloads REFP-1, so one tick every REFP cycles; the first tick is REFP cycles after rst deasserts.
- Combinational signals:
  - idle = ~|pread & ~|pwrite.
  - elig = ~refr_dis & (pend!=0) & (gap==0).
  - force = elig & (pend==MAXPEND).
  - prefr = elig & (idle | force), a one-cycle pulse.
- Gating:
  - ready = ~(force & ~idle).
  - pread_o = pread & {ready}; pwrite_o = pwrite & {ready}.
  - A blocked request is dropped, not queued; the requester must hold or retry on ready.
- Credit update, evaluated per cycle:
  - tick & ~prefr: pend+1 if pend<MAXPEND; else pend holds and refr_ovfl<=1.
  - prefr & ~tick: pend-1.
  - tick & prefr: pend unchanged, no overflow.
- Gap state machine:
  - IDLE (gap==0): on prefr, load gap=REFGAP-1 and go to GAP if REFGAP>1.
  - GAP: decrement each cycle; return to IDLE at 0.
  - With REFGAP=1, back-to-back prefr is legal.
- refr_dis:
  - Blocks prefr and force, so ready stays 1.
  - Credits saturate at MAXPEND; further ticks set refr_ovfl.
- refr_ovfl clears only on rst.
- Latency:
  - prefr, ready and the gated strobes are same-cycle combinational from inputs and registered state.
  - No pipeline delay is added to primary traffic.

Optional Feature:
- Macro: REFR_SCHED_STAT_EN.
- Defined: adds outputs refr_cnt [15:0] (total prefr pulses) and force_cnt [15:0] (pulses with force&~idle).
  - Both counters saturate at 16'hFFFF and reset to 0.
  - They also clear on a new input stat_clr (1-bit, synchronous; clear wins over increment).
- Undefined: no ports, registers or logic added.

Test Plan:
- REFP=16, MAXPEND=4, REFGAP=2; rst, then no traffic:
  - tick at cycle 16 -> pend=1, prefr pulses at cycle 17, pend back to 0.
  - Repeats every 16 cycles; ready always 1.
- Continuous pread=2'b11, refr_dis=0:
  - pend climbs 1..4 over 64 cycles.
  - On the cycle pend==4: prefr=1, ready=0, pread_o=0, pend->3.
  - Next tick forces again.
- refr_dis=1 for 100 cycles:
  - pend saturates at 4; refr_ovfl=1 after the 5th tick.
  - After release with no traffic: prefr fires 4 times, spaced 2 cycles apart, pend->0, refr_ovfl stays 1.
- Tick coincident with opportunistic prefr at pend=2 -> pend stays 2, refr_ovfl=0.
- Assert rst while pend=3 and gap=1 -> next cycle pend=0, prefr=0, timer=15, refr_ovfl=0.
- With REFR_SCHED_STAT_EN defined:
  - After scenario 2 for 4 forces -> refr_cnt=force_cnt=4.
  - stat_clr pulse -> both 0 next cycle.

Source files
------------

// File: rtl/refr_sched_1rw.sv
// Refresh scheduler for the 1RW multi-port mux.
// Accrues one refresh credit per REFP cycles, spends credits on idle cycles,
// forces a refresh (blocking primary traffic for one cycle) when credits
// reach MAXPEND, and keeps at least REFGAP cycles between refresh strobes.
// Optional statistics counters are enabled with `define REFR_SCHED_STAT_EN.
//
// Handshake: ready is a same-cycle qualifier for the primary strobes. When
// ready=0 the pread/pwrite request of that cycle is dropped (pread_o and
// pwrite_o are forced to 0); the requester must hold or retry until ready=1.
module refr_sched_1rw #(
    parameter int NUMRDPT = 1,
    parameter int NUMRWPT = 1,
    parameter int NUMWRPT = 2,
    parameter int REFP    = 64,
    parameter int MAXPEND = 8,
    parameter int BITPEND = 4,
    parameter int REFGAP  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUMRDPT+NUMRWPT-1:0] pread,
    input  logic [NUMRWPT+NUMWRPT-1:0] pwrite,
    input  logic                       refr_dis,
    output logic [NUMRDPT+NUMRWPT-1:0] pread_o,
    output logic [NUMRWPT+NUMWRPT-1:0] pwrite_o,
    output logic                       ready,
    output logic                       prefr,
    output logic [BITPEND-1:0]         refr_pend,
`ifdef REFR_SCHED_STAT_EN
    input  logic                       stat_clr,
    output logic [15:0]                refr_cnt,
    output logic [15:0]                force_cnt,
`endif
    output logic                       refr_ovfl
);

    localparam int TW = (REFP > 2) ? $clog2(REFP) : 1;
    localparam int GW = (REFGAP > 1) ? $clog2(REFGAP) : 1;
    localparam logic [TW-1:0]      TIMER_LOAD = TW'(REFP - 1);
    localparam logic [GW-1:0]      GAP_LOAD   = GW'(REFGAP - 1);
    localparam logic [BITPEND-1:0] PEND_MAX   = BITPEND'(MAXPEND);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GAP  = 1'b1
    } gap_state_t;

    logic [TW-1:0]      timer;
    logic               tick;
    logic [BITPEND-1:0] pend;
    logic [GW-1:0]      gap;
    logic [GW-1:0]      gap_nxt;
    gap_state_t         state;
    gap_state_t         state_nxt;
    logic               idle;
    logic               elig;
    logic               force_c;

    assign tick = (timer == '0);

    // Scheduling decision and strobe gating; reset holds the block transparent.
    always_comb begin
        idle     = ~|pread & ~|pwrite;
        elig     = ~rst & ~refr_dis & (pend != '0) & (state == S_IDLE);
        force_c  = elig & (pend == PEND_MAX);
        prefr    = elig & (idle | force_c);
        ready    = ~(force_c & ~idle);
        pread_o  = pread & {(NUMRDPT+NUMRWPT){ready}};
        pwrite_o = pwrite & {(NUMRWPT+NUMWRPT){ready}};
    end

    assign refr_pend = pend;

    // Refresh interval timer: one tick every REFP cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= TIMER_LOAD;
        end else if (tick) begin
            timer <= TIMER_LOAD;
        end else begin
            timer <= timer - 1'b1;
        end
    end

    // Credit counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= '0;
            refr_ovfl <= 1'b0;
        end else if (tick && !prefr) begin
            if (pend < PEND_MAX) begin
                pend <= pend + 1'b1;
            end else begin
                refr_ovfl <= 1'b1;
            end
        end else if (prefr && !tick) begin
            pend <= pend - 1'b1;
        end
    end

    // Gap FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            gap   <= '0;
        end else begin
            state <= state_nxt;
            gap   <= gap_nxt;
        end
    end

    // Gap FSM next state: after a refresh, hold off for REFGAP-1 cycles.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap;
        case (state)
            S_IDLE: begin
                if (prefr && (REFGAP > 1)) begin
                    gap_nxt   = GAP_LOAD;
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (gap <= GW'(1)) begin
                    gap_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    gap_nxt = gap - 1'b1;
                end
            end
            default: begin
                gap_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef REFR_SCHED_STAT_EN
    // Saturating counts of all refreshes and of forced (traffic-blocking) ones.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            refr_cnt  <= '0;
            force_cnt <= '0;
        end else begin
            if (prefr && (refr_cnt != 16'hFFFF)) begin
                refr_cnt <= refr_cnt + 16'd1;
            end
            if (force_c && !idle && (force_cnt != 16'hFFFF)) begin
                force_cnt <= force_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_refr_sched_1rw.sv
// Directed bench for refr_sched_1rw with REFP=16, MAXPEND=4, REFGAP=2.
// Cycle numbering: cycle 1 is the first cycle after rst deasserts.
module tb_refr_sched_1rw;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] pread;
    logic [2:0] pwrite;
    logic       refr_dis;
    logic [1:0] pread_o;
    logic [2:0] pwrite_o;
    logic       ready;
    logic       prefr;
    logic [3:0] refr_pend;
    logic       refr_ovfl;
`ifdef REFR_SCHED_STAT_EN
    logic        stat_clr;
    logic [15:0] refr_cnt;
    logic [15:0] force_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    refr_sched_1rw #(
        .NUMRDPT(1), .NUMRWPT(1), .NUMWRPT(2),
        .REFP(16), .MAXPEND(4), .BITPEND(4), .REFGAP(2)
    ) dut (
        .clk(clk), .rst(rst), .pread(pread), .pwrite(pwrite),
        .refr_dis(refr_dis), .pread_o(pread_o), .pwrite_o(pwrite_o),
        .ready(ready), .prefr(prefr), .refr_pend(refr_pend),
`ifdef REFR_SCHED_STAT_EN
        .stat_clr(stat_clr), .refr_cnt(refr_cnt), .force_cnt(force_cnt),
`endif
        .refr_ovfl(refr_ovfl)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // Driver tasks.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) next_cycle();
        settle();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        pread    = '0;
        pwrite   = '0;
        refr_dis = 1'b0;
`ifdef REFR_SCHED_STAT_EN
        stat_clr = 1'b0;
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc = 1;
        settle();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        pread    = 2'b11;
        pwrite   = 3'b010;
        refr_dis = 1'b0;
`ifdef REFR_SCHED_STAT_EN
        stat_clr = 1'b0;
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if ({prefr, ready, pread_o, pwrite_o} !== {1'b0, 1'b1, 2'b11, 3'b010})
            $display("FAIL rst_passthru: got prefr=%b ready=%b pread_o=%b pwrite_o=%b, want 0 1 11 010",
                     prefr, ready, pread_o, pwrite_o);
        else n_pass++;
        n_checks++;
        if (refr_pend !== 4'd0 || refr_ovfl !== 1'b0)
            $display("FAIL rst_state: got pend=%0d ovfl=%b, want 0 0", refr_pend, refr_ovfl);
        else n_pass++;
        n_checks++;
        if (dut.timer !== 4'd15)
            $display("FAIL rst_timer: got %0d, want 15", dut.timer);
        else n_pass++;
    endtask

    // No traffic: one tick every 16 cycles, refreshed on the next cycle.
    task automatic test_idle_refresh();
        logic exp_prefr;
        logic [3:0] exp_pend;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            run_to(k);
            exp_prefr = (k == 17) || (k == 33);
            exp_pend  = exp_prefr ? 4'd1 : 4'd0;
            n_checks++;
            if (prefr !== exp_prefr || ready !== 1'b1 || refr_pend !== exp_pend)
                $display("FAIL idle_refresh c%0d: got prefr=%b ready=%b pend=%0d, want %b 1 %0d",
                         k, prefr, ready, refr_pend, exp_prefr, exp_pend);
            else n_pass++;
        end
    endtask

    // Continuous traffic: credits climb to 4 and then force a refresh.
    task automatic test_force();
        do_reset();
        pread  = 2'b11;
        pwrite = 3'b101;
        run_to(33);
        n_checks++;
        if (refr_pend !== 4'd2 || prefr !== 1'b0)
            $display("FAIL force_climb: got pend=%0d prefr=%b, want 2 0", refr_pend, prefr);
        else n_pass++;
        run_to(64);
        n_checks++;
        if (refr_pend !== 4'd3 || ready !== 1'b1 || pread_o !== 2'b11)
            $display("FAIL force_pre: got pend=%0d ready=%b pread_o=%b, want 3 1 11", refr_pend, ready, pread_o);
        else n_pass++;
        run_to(65);
        n_checks++;
        if ({refr_pend, prefr, ready, pread_o, pwrite_o} !== {4'd4, 1'b1, 1'b0, 2'b00, 3'b000})
            $display("FAIL force_hit: got pend=%0d prefr=%b ready=%b pread_o=%b pwrite_o=%b, want 4 1 0 00 000",
                     refr_pend, prefr, ready, pread_o, pwrite_o);
        else n_pass++;
        run_to(66);
        n_checks++;
        if ({refr_pend, prefr, ready, pread_o, pwrite_o} !== {4'd3, 1'b0, 1'b1, 2'b11, 3'b101})
            $display("FAIL force_post: got pend=%0d prefr=%b ready=%b pread_o=%b pwrite_o=%b, want 3 0 1 11 101",
                     refr_pend, prefr, ready, pread_o, pwrite_o);
        else n_pass++;
        run_to(80);
        n_checks++;
        if (prefr !== 1'b0 || ready !== 1'b1)
            $display("FAIL force_wait: got prefr=%b ready=%b, want 0 1", prefr, ready);
        else n_pass++;
        run_to(81);
        n_checks++;
        if (refr_pend !== 4'd4 || prefr !== 1'b1 || ready !== 1'b0)
            $display("FAIL force_again: got pend=%0d prefr=%b ready=%b, want 4 1 0", refr_pend, prefr, ready);
        else n_pass++;
        run_to(114);
        n_checks++;
        if (refr_pend !== 4'd3 || refr_ovfl !== 1'b0)
            $display("FAIL force_end: got pend=%0d ovfl=%b, want 3 0", refr_pend, refr_ovfl);
        else n_pass++;
`ifdef REFR_SCHED_STAT_EN
        n_checks++;
        if (refr_cnt !== 16'd4 || force_cnt !== 16'd4)
            $display("FAIL stat_cnt: got refr_cnt=%0d force_cnt=%0d, want 4 4", refr_cnt, force_cnt);
        else n_pass++;
        stat_clr = 1'b1;
        next_cycle();
        stat_clr = 1'b0;
        settle();
        n_checks++;
        if (refr_cnt !== 16'd0 || force_cnt !== 16'd0)
            $display("FAIL stat_clr: got refr_cnt=%0d force_cnt=%0d, want 0 0", refr_cnt, force_cnt);
        else n_pass++;
`endif
        pread  = '0;
        pwrite = '0;
    endtask

    // refr_dis: saturation, overflow, then drain with REFGAP spacing.
    task automatic test_disable();
        logic exp_prefr;
        do_reset();
        refr_dis = 1'b1;
        run_to(80);
        n_checks++;
        if (refr_pend !== 4'd4 || refr_ovfl !== 1'b0 || prefr !== 1'b0 || ready !== 1'b1)
            $display("FAIL dis_sat: got pend=%0d ovfl=%b prefr=%b ready=%b, want 4 0 0 1",
                     refr_pend, refr_ovfl, prefr, ready);
        else n_pass++;
        run_to(81);
        n_checks++;
        if (refr_pend !== 4'd4 || refr_ovfl !== 1'b1)
            $display("FAIL dis_ovfl: got pend=%0d ovfl=%b, want 4 1", refr_pend, refr_ovfl);
        else n_pass++;
        run_to(101);
        refr_dis = 1'b0;
        for (int k = 101; k <= 108; k++) begin
            run_to(k);
            exp_prefr = (k % 2) == 1;
            n_checks++;
            if (prefr !== exp_prefr || ready !== 1'b1)
                $display("FAIL drain c%0d: got prefr=%b ready=%b, want %b 1", k, prefr, ready, exp_prefr);
            else n_pass++;
        end
        n_checks++;
        if (refr_pend !== 4'd0 || refr_ovfl !== 1'b1)
            $display("FAIL drain_end: got pend=%0d ovfl=%b, want 0 1", refr_pend, refr_ovfl);
        else n_pass++;
    endtask

    // Tick in the same cycle as an opportunistic refresh at pend=2.
    task automatic test_tick_coincident();
        do_reset();
        refr_dis = 1'b1;
        run_to(48);
        refr_dis = 1'b0;
        settle();
        n_checks++;
        if (prefr !== 1'b1 || refr_pend !== 4'd2)
            $display("FAIL coinc_fire: got prefr=%b pend=%0d, want 1 2", prefr, refr_pend);
        else n_pass++;
        run_to(49);
        n_checks++;
        if (refr_pend !== 4'd2 || refr_ovfl !== 1'b0 || prefr !== 1'b0)
            $display("FAIL coinc_hold: got pend=%0d ovfl=%b prefr=%b, want 2 0 0", refr_pend, refr_ovfl, prefr);
        else n_pass++;
    endtask

    // Reset while pend=3, gap active and overflow set.
    task automatic test_mid_reset();
        do_reset();
        refr_dis = 1'b1;
        run_to(81);
        refr_dis = 1'b0;
        settle();
        n_checks++;
        if (prefr !== 1'b1 || refr_ovfl !== 1'b1)
            $display("FAIL mid_fire: got prefr=%b ovfl=%b, want 1 1", prefr, refr_ovfl);
        else n_pass++;
        run_to(82);
        n_checks++;
        if (refr_pend !== 4'd3 || dut.gap !== 1'b1)
            $display("FAIL mid_pre: got pend=%0d gap=%0d, want 3 1", refr_pend, dut.gap);
        else n_pass++;
        rst   = 1'b1;
        pread = 2'b10;
        settle();
        n_checks++;
        if (prefr !== 1'b0 || ready !== 1'b1 || pread_o !== 2'b10)
            $display("FAIL mid_rst: got prefr=%b ready=%b pread_o=%b, want 0 1 10", prefr, ready, pread_o);
        else n_pass++;
        next_cycle();
        rst   = 1'b0;
        pread = '0;
        settle();
        n_checks++;
        if ({refr_pend, prefr, refr_ovfl} !== {4'd0, 1'b0, 1'b0} || dut.timer !== 4'd15)
            $display("FAIL mid_after: got pend=%0d prefr=%b ovfl=%b timer=%0d, want 0 0 0 15",
                     refr_pend, prefr, refr_ovfl, dut.timer);
        else n_pass++;
    endtask

    // Sequence and final report.
    initial begin
        test_reset();
        test_idle_refresh();
        test_force();
        test_disable();
        test_tick_coincident();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
